ovl_fire_monitor: RTL

- Downstream consumer of the `fire` outputs of a bank of OVL checkers.
- Each checker drives a 3-bit fire vector: bit0 = 2-state assertion failure, bit1 = X-check failure, bit2 = cover hit.
- The block concatenates NUM_CHECKERS fire vectors and keeps sticky status, saturating failure counters and a first-failure record.
- It also maintains a timestamped event FIFO that a testbench or debug bus drains through a valid/ready handshake.

---
 rtl/ovl_fire_mon_pkg.sv | 28 ++
 rtl/ovl_fire_fifo.sv | 47 ++++
 rtl/ovl_fire_monitor.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/ovl_fire_mon_pkg.sv
// Shared constants and helpers for the OVL fire monitor.
// Fire vector bit positions, a wide saturating add and a population count.
package ovl_fire_mon_pkg;

  localparam int FIRE_W       = 3;
  localparam int FAIL_BIT     = 0;
  localparam int XCHK_BIT     = 1;
  localparam int COVER_BIT    = 2;
  localparam int MAX_CHECKERS = 32;
  localparam int SAT_W        = 64;

  // Operands are zero-extended by the caller, so the sum cannot wrap for any legal CNT_W.
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                                input logic [SAT_W-1:0] b,
                                                input logic [SAT_W-1:0] max);
    logic [SAT_W-1:0] sum;
    sum = a + b;
    return (sum > max) ? max : sum;
  endfunction

  function automatic logic [5:0] popcount(input logic [MAX_CHECKERS-1:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < MAX_CHECKERS; i++) n = n + {5'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/ovl_fire_fifo.sv
// Synchronous event FIFO with flush; head is read straight from the register array.
// A push while full is only written when the same cycle also pops.
module ovl_fire_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; validity is tracked purely by the pointers.
  always_ff @(posedge clock) begin
    if (do_push && !reset && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ovl_fire_monitor.sv
// Aggregates OVL checker fire vectors into sticky status, saturating counters and a timestamped event FIFO.
// Define OVL_FIRE_MON_COVER_EN to add cover_count / cover_seen; otherwise cover bits are ignored.
module ovl_fire_monitor
  import ovl_fire_mon_pkg::*;
#(
  parameter int NUM_CHECKERS = 4,
  parameter int CNT_W        = 16,
  parameter int TS_W         = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int ID_W         = 5
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           clear,
  input  logic [NUM_CHECKERS*FIRE_W-1:0] fire_in,
  output logic                           any_fail,
  output logic                           first_fail_valid,
  output logic [ID_W-1:0]                first_fail_id,
  output logic [CNT_W-1:0]               fail_count,
  output logic [CNT_W-1:0]               xcheck_count,
  output logic                           evt_valid,
  input  logic                           evt_ready,
  output logic [TS_W+2*NUM_CHECKERS-1:0] evt_data,
  output logic                           evt_overflow,
`ifdef OVL_FIRE_MON_COVER_EN
  output logic [CNT_W-1:0]               cover_count,
  output logic [NUM_CHECKERS-1:0]        cover_seen,
`endif
  output logic [CNT_W-1:0]               drop_count
);

  localparam int              EVT_W   = TS_W + 2*NUM_CHECKERS;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [TS_W-1:0]         ts;
    logic [NUM_CHECKERS-1:0] xchk_mask;
    logic [NUM_CHECKERS-1:0] fail_mask;
  } evt_entry_t;

  logic [TS_W-1:0]         ts;
  logic [NUM_CHECKERS-1:0] fail_mask;
  logic [NUM_CHECKERS-1:0] xchk_mask;
  logic [NUM_CHECKERS-1:0] cover_mask;
  logic [ID_W-1:0]         first_idx;
  logic [5:0]              fail_pop;
  logic [5:0]              xchk_pop;
  logic [CNT_W-1:0]        fail_next;
  logic [CNT_W-1:0]        xchk_next;
  logic [CNT_W-1:0]        drop_next;
  logic                    sample;
  logic                    push;
  logic                    pop;
  logic                    drop;
  logic                    fifo_full;
  logic                    fifo_empty;
  evt_entry_t              push_entry;
  logic [EVT_W-1:0]        head;

  assign sample = enable && !clear;

  always_comb begin
    fail_mask  = '0;
    xchk_mask  = '0;
    cover_mask = '0;
    for (int k = 0; k < NUM_CHECKERS; k++) begin
      fail_mask[k]  = fire_in[k*FIRE_W + FAIL_BIT];
      xchk_mask[k]  = fire_in[k*FIRE_W + XCHK_BIT];
      cover_mask[k] = fire_in[k*FIRE_W + COVER_BIT];
    end
  end

  always_comb begin
    first_idx = '0;
    for (int k = NUM_CHECKERS-1; k >= 0; k--) begin
      if (fail_mask[k]) first_idx = ID_W'(k);
    end
  end

  assign fail_pop  = popcount(MAX_CHECKERS'(fail_mask));
  assign xchk_pop  = popcount(MAX_CHECKERS'(xchk_mask));
  assign fail_next = CNT_W'(sat_add(SAT_W'(fail_count), SAT_W'(fail_pop), SAT_W'(CNT_MAX)));
  assign xchk_next = CNT_W'(sat_add(SAT_W'(xcheck_count), SAT_W'(xchk_pop), SAT_W'(CNT_MAX)));
  assign drop_next = CNT_W'(sat_add(SAT_W'(drop_count), SAT_W'(1), SAT_W'(CNT_MAX)));

  assign push       = sample && ((|fail_mask) || (|xchk_mask));
  // A handshake coinciding with clear is discarded along with the flush.
  assign pop        = evt_valid && evt_ready && !clear;
  assign drop       = push && fifo_full && !pop;
  assign push_entry = '{ts: ts, xchk_mask: xchk_mask, fail_mask: fail_mask};

  always_ff @(posedge clock) begin
    if (reset) ts <= '0;
    else       ts <= ts + TS_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      any_fail         <= 1'b0;
      first_fail_valid <= 1'b0;
      first_fail_id    <= '0;
      fail_count       <= '0;
      xcheck_count     <= '0;
      evt_overflow     <= 1'b0;
      drop_count       <= '0;
    end else if (sample) begin
      fail_count   <= fail_next;
      xcheck_count <= xchk_next;
      if (|fail_mask) begin
        any_fail <= 1'b1;
        if (!first_fail_valid) begin
          first_fail_valid <= 1'b1;
          first_fail_id    <= first_idx;
        end
      end
      if (drop) begin
        evt_overflow <= 1'b1;
        drop_count   <= drop_next;
      end
    end
  end

`ifdef OVL_FIRE_MON_COVER_EN
  logic [5:0]       cover_pop;
  logic [CNT_W-1:0] cover_next;

  assign cover_pop  = popcount(MAX_CHECKERS'(cover_mask));
  assign cover_next = CNT_W'(sat_add(SAT_W'(cover_count), SAT_W'(cover_pop), SAT_W'(CNT_MAX)));

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cover_count <= '0;
      cover_seen  <= '0;
    end else if (sample) begin
      cover_count <= cover_next;
      cover_seen  <= cover_seen | cover_mask;
    end
  end
`else
  logic unused_cover;
  assign unused_cover = ^cover_mask;
`endif

  ovl_fire_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (clear),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign evt_valid = !fifo_empty;
  // Masked so the bus reads zero after reset rather than stale storage.
  assign evt_data  = evt_valid ? head : '0;

endmodule
